zap_mac_sequencer: RTL and testbench
====================================

// Module: zap_mac_sequencer
// PURPOSE
//  Iterative 32x32+32 multiply-accumulate responder: Rd = (Rm*Rs + Rn) mod 2^32.
//  Serves the shift stage. The shift stage holds i_start and the operands while
//  an MLA sits at its input, and stalls on o_busy. Shift-add over BITS_PER_CYCLE
//  multiplier bits per cycle, with optional early exit when the remaining
//  multiplier bits are zero.
// PARAMETERS
//  BITS_PER_CYCLE  2  multiplier bits retired per BUSY cycle; legal 1,2,4,8 (divides 32)
//  EARLY_EXIT      1  1: leave BUSY once the remaining multiplier is zero; 0: always 32/BITS_PER_CYCLE cycles
// PORTS
//  i_clk      in   1   clock, rising edge
//  i_reset    in   1   asynchronous, active-high reset
//  i_clear    in   1   synchronous flush (writeback/ALU clear); aborts any operation
//  i_stall    in   1   downstream data stall; holds a finished result
//  i_start    in   1   level request; high while an MLA is presented
//  i_rm       in   32  multiplicand, sampled in IDLE when i_start=1
//  i_rs       in   32  multiplier, sampled in IDLE when i_start=1
//  i_rn       in   32  accumulate addend, sampled in IDLE when i_start=1
//  o_rd       out  32  result, valid while state==DONE (registered)
//  o_busy     out  1   stall request to the shift stage (combinational)
// BEHAVIOUR
//  States: IDLE, BUSY, DONE (2-bit encoded).
//  Reset: state=IDLE, o_rd=0, internal acc/mcand/mplier/count=0. o_busy=0 while reset is asserted.
//  Priority each edge: i_reset > i_clear > i_stall > normal operation.
//  IDLE, i_start=1, i_clear=0:
//   - load acc=i_rn, mcand=i_rm, mplier=i_rs, count=0
//   - next state BUSY
//  BUSY, each cycle:
//   - acc   += mcand * mplier[B-1:0]   (B = BITS_PER_CYCLE; 32-bit wrap, carries beyond bit 31 discarded)
//   - mcand <<= B; mplier >>= B; count += 1
//   - go to DONE when count reaches 32/B-1 on this cycle
//   - with EARLY_EXIT=1, also go to DONE when the shifted mplier is 0
//   - mplier==0 at load: exactly one BUSY cycle, then DONE with acc=i_rn
//   - i_stall does not pause BUSY; its operands are already captured
//  DONE:
//   - o_rd=acc
//   - i_stall=1: remain DONE and hold o_rd
//   - i_stall=0: next state IDLE. The consumer captures o_rd on this edge.
//   - a new i_start seen in IDLE on the next cycle is a new, back-to-back request.
//  o_busy = !i_clear && ((state==IDLE && i_start) || state==BUSY).
//   - o_busy is 0 in DONE, so the result-consuming cycle is not stalled.
//  Latency: request at cycle T (IDLE)
//   -> BUSY cycles T+1 .. T+N, with N = 32/B (or fewer with early exit)
//   -> DONE at T+N+1.
//   o_busy is high for cycles T..T+N. With B=2 and no early exit, N=16.
//  i_clear in any state:
//   - next state IDLE; o_rd keeps its value
//   - the request is dropped; a held i_start restarts from IDLE the cycle after the clear
//  i_reset mid-BUSY: immediate (asynchronous) return to reset values; no partial result is visible.
//  Operands changing during BUSY/DONE are ignored; only the IDLE-sample is used.
//  Signedness irrelevant: the low 32 bits are identical for signed and unsigned operands.
// TESTING
//  1. EARLY_EXIT=0, B=2: rm=3, rs=5, rn=7, i_start held
//     -> o_busy high 17 cycles; DONE; o_rd=22
//  2. Wrap: rm=0xFFFFFFFF, rs=0xFFFFFFFF, rn=1
//     -> o_rd=0x00000002
//  3. Early exit, B=2: rs=1, rm=0x1234, rn=0
//     -> exactly 1 BUSY cycle; o_rd=0x1234
//  4. i_clear asserted at the 5th BUSY cycle
//     -> next state IDLE; o_busy=0 that cycle; o_rd unchanged
//  5. DONE with i_stall high for 3 cycles
//     -> o_rd held stable, o_busy=0
//     -> then IDLE, and back-to-back request rm=2, rs=2, rn=0 gives o_rd=4
//  6. Random operands, B in {1,2,4,8} x EARLY_EXIT in {0,1}
//     -> o_rd == (rm*rs+rn)[31:0]; BUSY cycles <= 32/B

Source files
------------

// File: rtl/zap_mac_sequencer.sv
// Iterative 32x32+32 multiply-accumulate unit (Rd = Rm*Rs + Rn mod 2^32).
// Retires BITS_PER_CYCLE multiplier bits per BUSY cycle, optionally exiting early.
module zap_mac_sequencer #(
  parameter int BITS_PER_CYCLE = 2,
  parameter int EARLY_EXIT     = 1
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_clear,
  input  logic        i_stall,
  input  logic        i_start,
  input  logic [31:0] i_rm,
  input  logic [31:0] i_rs,
  input  logic [31:0] i_rn,
  output logic [31:0] o_rd,
  output logic        o_busy
);

  localparam int         B     = BITS_PER_CYCLE;
  localparam int         STEPS = 32 / B;
  localparam logic [5:0] LAST  = 6'(STEPS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] mcand_q, mcand_d;
  logic [31:0] mplier_q, mplier_d;
  logic [31:0] rd_q, rd_d;
  logic [5:0]  count_q, count_d;
  logic [31:0] mplier_shift_s;
  logic [31:0] acc_step_s;
  logic        busy_last_s;

  // Sum of the shifted multiplicand for each set multiplier bit in this slice.
  function automatic logic [31:0] partial_product(input logic [31:0] mcand,
                                                  input logic [B-1:0] bits);
    logic [31:0] sum;
    sum = 32'd0;
    for (int i = 0; i < B; i++) begin
      sum = sum + ((mcand & {32{bits[i]}}) << i);
    end
    return sum;
  endfunction

  // Per-cycle step values and the BUSY termination condition.
  always_comb begin
    mplier_shift_s = mplier_q >> B;
    acc_step_s     = acc_q + partial_product(mcand_q, mplier_q[B-1:0]);
    busy_last_s    = (count_q == LAST) ||
                     ((EARLY_EXIT != 0) && (mplier_shift_s == 32'd0));
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a clear always returns to IDLE.
  always_comb begin
    state_d = state_q;
    if (i_clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (i_start)     state_d = BUSY; else state_d = IDLE;
        BUSY:    if (busy_last_s) state_d = DONE; else state_d = BUSY;
        DONE:    if (i_stall)     state_d = DONE; else state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Datapath next values: load in IDLE, shift-add in BUSY, otherwise hold.
  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    count_d  = count_q;
    rd_d     = rd_q;
    if (!i_clear && (state_q == IDLE) && i_start) begin
      acc_d    = i_rn;
      mcand_d  = i_rm;
      mplier_d = i_rs;
      count_d  = 6'd0;
    end else if (!i_clear && (state_q == BUSY)) begin
      acc_d    = acc_step_s;
      mcand_d  = mcand_q << B;
      mplier_d = mplier_shift_s;
      count_d  = count_q + 6'd1;
      if (busy_last_s) begin
        rd_d = acc_step_s;
      end else begin
        rd_d = rd_q;
      end
    end else begin
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      count_d  = count_q;
      rd_d     = rd_q;
    end
  end

  // Datapath registers.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      acc_q    <= 32'd0;
      mcand_q  <= 32'd0;
      mplier_q <= 32'd0;
      count_q  <= 6'd0;
      rd_q     <= 32'd0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      count_q  <= count_d;
      rd_q     <= rd_d;
    end
  end

  // Outputs; busy drops in DONE so the consuming cycle is never stalled.
  always_comb begin
    o_rd   = rd_q;
    o_busy = !i_reset && !i_clear &&
             (((state_q == IDLE) && i_start) || (state_q == BUSY));
  end

endmodule

// File: tb/tb_zap_mac_sequencer.sv
// Scoreboard bench for zap_mac_sequencer over all BITS_PER_CYCLE x EARLY_EXIT configurations.
module tb_zap_mac_sequencer;

  logic        clk   = 1'b0;
  logic        rst   = 1'b0;
  logic        clear = 1'b0;
  logic        stall = 1'b0;
  logic        start_s [8];
  logic [31:0] rm = 32'd0, rs = 32'd0, rn = 32'd0;
  logic [31:0] rd_o [8];
  logic        busy_o [8];
  logic [31:0] exp_q [$];
  int          checks = 0;
  int          fails  = 0;

  always #5 clk = ~clk;

  // Instance g: BITS_PER_CYCLE = 1 << (g/2), EARLY_EXIT = g % 2
  for (genvar g = 0; g < 8; g++) begin : g_dut
    zap_mac_sequencer #(
      .BITS_PER_CYCLE(1 << (g / 2)),
      .EARLY_EXIT    (g % 2)
    ) dut (
      .i_clk  (clk),
      .i_reset(rst),
      .i_clear(clear),
      .i_stall(stall),
      .i_start(start_s[g]),
      .i_rm   (rm),
      .i_rs   (rs),
      .i_rn   (rn),
      .o_rd   (rd_o[g]),
      .o_busy (busy_o[g])
    );
  end

  // Entered just after the request cycle's inputs are driven; counts busy cycles up to DONE
  task automatic wait_done(input int k, input bit hold, output int cycles);
    logic [31:0] expv;
    cycles = 0;
    while (busy_o[k] === 1'b1 && cycles < 100) begin
      cycles++;
      @(negedge clk);
      if (!hold) start_s[k] = 1'b0;
      #1;
    end
    start_s[k] = 1'b0;
    checks++;
    if (cycles >= 100) begin
      fails++;
      $display("FAIL done_timeout inst=%0d busy_cycles=%0d required<100", k, cycles);
    end
    expv = exp_q.pop_front();
    checks++;
    if (rd_o[k] !== expv) begin
      fails++;
      $display("FAIL result inst=%0d got=%h expected=%h", k, rd_o[k], expv);
    end
  endtask

  task automatic run_op(input int k, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] c, input bit hold, output int cycles);
    logic [31:0] expv;
    @(negedge clk);
    rm = a; rs = b; rn = c;
    start_s[k] = 1'b1;
    expv = a * b + c;
    exp_q.push_back(expv);
    #1;
    wait_done(k, hold, cycles);
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    for (int i = 0; i < 8; i++) start_s[i] = 1'b1;
    #2;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (busy_o[i] !== 1'b0) begin
        fails++; $display("FAIL reset_busy inst=%0d got=%b expected=0", i, busy_o[i]);
      end
    end
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (rd_o[i] !== 32'd0) begin
        fails++; $display("FAIL reset_rd inst=%0d got=%h expected=0", i, rd_o[i]);
      end
      start_s[i] = 1'b0;
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int cyc;
    run_op(2, 32'd3, 32'd5, 32'd7, 1'b1, cyc);
    checks++;
    if (cyc != 17) begin
      fails++; $display("FAIL basic_busy_cycles got=%0d expected=17", cyc);
    end
    checks++;
    if (rd_o[2] !== 32'd22) begin
      fails++; $display("FAIL basic_rd got=%h expected=00000016", rd_o[2]);
    end
  endtask

  task automatic test_wrap();
    int cyc;
    run_op(2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 1'b0, cyc);
    checks++;
    if (rd_o[2] !== 32'h0000_0002) begin
      fails++; $display("FAIL wrap_rd got=%h expected=00000002", rd_o[2]);
    end
  endtask

  task automatic test_early_exit();
    int cyc;
    run_op(3, 32'h1234, 32'd1, 32'd0, 1'b0, cyc);
    checks++;
    if (cyc != 2) begin
      fails++; $display("FAIL early_exit_cycles got=%0d expected=2", cyc);
    end
    run_op(3, 32'hDEAD_BEEF, 32'd0, 32'h55, 1'b0, cyc);
    checks++;
    if (cyc != 2) begin
      fails++; $display("FAIL zero_mplier_ee_cycles got=%0d expected=2", cyc);
    end
    run_op(2, 32'hDEAD_BEEF, 32'd0, 32'h66, 1'b0, cyc);
    checks++;
    if (cyc != 17) begin
      fails++; $display("FAIL zero_mplier_noee_cycles got=%0d expected=17", cyc);
    end
  endtask

  task automatic test_clear();
    int          cyc;
    logic [31:0] expv;
    @(negedge clk);
    rm = 32'h0001_0003; rs = 32'hF0F0_F0F1; rn = 32'd9;
    start_s[2] = 1'b1;
    repeat (5) @(negedge clk);
    clear = 1'b1;
    #1;
    checks++;
    if (busy_o[2] !== 1'b0) begin
      fails++; $display("FAIL clear_busy got=%b expected=0", busy_o[2]);
    end
    @(negedge clk);
    clear = 1'b0;
    #1;
    checks++;
    if (rd_o[2] !== 32'h66) begin
      fails++; $display("FAIL clear_rd_kept got=%h expected=00000066", rd_o[2]);
    end
    checks++;
    if (busy_o[2] !== 1'b1) begin
      fails++; $display("FAIL clear_restart_busy got=%b expected=1", busy_o[2]);
    end
    expv = rm * rs + rn;
    exp_q.push_back(expv);
    wait_done(2, 1'b1, cyc);
    checks++;
    if (cyc != 17) begin
      fails++; $display("FAIL clear_restart_cycles got=%0d expected=17", cyc);
    end
  endtask

  task automatic test_stall_back_to_back();
    int cyc;
    run_op(2, 32'd9, 32'd11, 32'd4, 1'b0, cyc);
    stall = 1'b1;
    repeat (3) begin
      @(negedge clk);
      #1;
      checks++;
      if (rd_o[2] !== 32'd103 || busy_o[2] !== 1'b0) begin
        fails++;
        $display("FAIL stall_hold rd=%h busy=%b expected rd=00000067 busy=0", rd_o[2], busy_o[2]);
      end
    end
    stall = 1'b0;
    run_op(2, 32'd2, 32'd2, 32'd0, 1'b0, cyc);
    checks++;
    if (rd_o[2] !== 32'd4) begin
      fails++; $display("FAIL back_to_back_rd got=%h expected=00000004", rd_o[2]);
    end
  endtask

  task automatic test_reset_mid_busy();
    @(negedge clk);
    rm = 32'd77; rs = 32'hFFFF_0000; rn = 32'd1;
    start_s[2] = 1'b1;
    @(negedge clk);
    start_s[2] = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (busy_o[2] !== 1'b0 || rd_o[2] !== 32'd0) begin
      fails++;
      $display("FAIL reset_mid_busy busy=%b rd=%h expected busy=0 rd=00000000", busy_o[2], rd_o[2]);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_random();
    int          cyc;
    int          steps;
    logic [31:0] a, b, c;
    for (int k = 0; k < 8; k++) begin
      steps = 32 >> (k / 2);
      for (int n = 0; n < 12; n++) begin
        a = $urandom;
        c = $urandom;
        if (n == 0)          b = 32'd0;
        else if (n % 3 == 1) b = 32'($urandom_range(0, 255));
        else                 b = $urandom;
        run_op(k, a, b, c, 1'b0, cyc);
        checks++;
        if (cyc < 2 || cyc > steps + 1 || ((k % 2 == 0) && cyc != steps + 1)) begin
          fails++;
          $display("FAIL random_latency inst=%0d busy_cycles=%0d bound=%0d", k, cyc, steps + 1);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) start_s[i] = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_early_exit();
    test_clear();
    test_stall_back_to_back();
    test_reset_mid_busy();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
